// File: rtl/serial_tx.sv
// Parallel-to-serial frame transmitter: start bit, DATA_W data bits LSB first, stop bit.
// Each serial bit is held for CLKS_PER_BIT clocks; the line idles high.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int BIT_W  = $clog2(DATA_W) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t              state_reg, state_next;
    logic [BAUD_W-1:0]   baud_reg, baud_next;
    logic [BIT_W-1:0]    bit_reg, bit_next;
    logic [DATA_W-1:0]   shift_reg, shift_next;
    logic                tx_next, ready_next, busy_next, done_next;
    logic                bit_end;

    // State register; outputs are registered copies of the values decoded for the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            ready     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            ready     <= ready_next;
            busy      <= busy_next;
            done      <= done_next;
        end
    end

    assign bit_end = (baud_reg == BAUD_LAST);

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                if (valid && ready) begin
                    shift_next = data;
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_next = '0;
                    if (bit_reg == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_next   = bit_reg + 1'b1;
                        shift_next = shift_reg >> 1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_next  = '0;
                    state_next = IDLE;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the next state, so done lands in the last cycle of the stop bit
    always_comb begin
        tx_next    = 1'b1;
        ready_next = 1'b0;
        busy_next  = 1'b1;
        done_next  = 1'b0;
        case (state_next)
            IDLE: begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
            START: tx_next = 1'b0;
            DATA:  tx_next = shift_next[0];
            STOP:  done_next = (baud_next == BAUD_LAST);
            default: begin
                ready_next = 1'b1;
                busy_next  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data0 = 8'h00;
    logic       valid0 = 1'b0;
    logic       ready0, tx0, busy0, done0;
    logic [7:0] data1 = 8'h00;
    logic       valid1 = 1'b0;
    logic       ready1, tx1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0, t1, tdummy;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .data(data0), .valid(valid0),
        .ready(ready0), .tx(tx0), .busy(busy0), .done(done0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .data(data1), .valid(valid1),
        .ready(ready1), .tx(tx1), .busy(busy1), .done(done1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic tx_of(input bit s);   return s ? tx1 : tx0;       endfunction
    function automatic logic done_of(input bit s); return s ? done1 : done0;   endfunction
    function automatic logic busy_of(input bit s); return s ? busy1 : busy0;   endfunction
    function automatic logic rdy_of(input bit s);  return s ? ready1 : ready0; endfunction

    // Caller presents data/valid; this task takes the acceptance edge and checks every frame cycle.
    // pat[i] is the hand-derived level of serial bit i (start, d0..d7, stop).
    task automatic frame(input bit sel, input int cpb, input logic [9:0] pat,
                         input bit keep_valid, input logic [7:0] next_data,
                         input bit disturb, output int done_at);
        int n;
        n = 10 * cpb;
        done_at = -1;
        tick();
        if (sel) valid1 = 1'b0;
        else if (keep_valid) data0 = next_data;
        else valid0 = 1'b0;
        for (int c = 1; c <= n; c++) begin
            chk($sformatf("tx[%0d] c%0d", sel, c), tx_of(sel), pat[(c-1)/cpb]);
            chk($sformatf("done[%0d] c%0d", sel, c), done_of(sel), (c == n));
            chk($sformatf("busy[%0d] c%0d", sel, c), busy_of(sel), 1'b1);
            chk($sformatf("ready[%0d] c%0d", sel, c), rdy_of(sel), 1'b0);
            if (done_of(sel)) done_at = cyc;
            if (disturb && c < n) begin
                data0  = 8'h3C;
                valid0 = ~valid0;
            end
            if (c < n) tick();
        end
    endtask

    initial begin
        // Reset: asserted before any clock edge, outputs must settle immediately
        #2 rst = 1'b1;
        #1;
        chk("rst tx", tx0, 1'b1);
        chk("rst ready", ready0, 1'b0);
        chk("rst busy", busy0, 1'b0);
        chk("rst done", done0, 1'b0);
        repeat (2) tick();
        chk("rst hold ready", ready0, 1'b0);
        rst = 1'b0;
        #1;
        chk("release no edge ready", ready0, 1'b0);
        tick();
        chk("release ready", ready0, 1'b1);
        chk("release ready1", ready1, 1'b1);
        chk("release busy", busy0, 1'b0);
        chk("release tx", tx0, 1'b1);

        // Single frame A5
        data0 = 8'hA5; valid0 = 1'b1;
        frame(1'b0, 4, 10'h34A, 1'b0, 8'h00, 1'b0, tdummy);
        tick();
        chk("A5 end ready", ready0, 1'b1);
        chk("A5 end busy", busy0, 1'b0);
        chk("A5 end done", done0, 1'b0);

        // A5 again while data/valid are disturbed during the frame
        data0 = 8'hA5; valid0 = 1'b1;
        frame(1'b0, 4, 10'h34A, 1'b0, 8'h00, 1'b1, tdummy);
        valid0 = 1'b0;
        tick();
        chk("dist end ready", ready0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dist idle tx", tx0, 1'b1);
            chk("dist idle busy", busy0, 1'b0);
        end

        // Back-to-back 00 then FF with valid held
        data0 = 8'h00; valid0 = 1'b1;
        frame(1'b0, 4, 10'h200, 1'b1, 8'hFF, 1'b0, t0);
        tick();
        chk("b2b idle tx", tx0, 1'b1);
        chk("b2b idle ready", ready0, 1'b1);
        chk("b2b idle busy", busy0, 1'b0);
        frame(1'b0, 4, 10'h3FE, 1'b0, 8'h00, 1'b0, t1);
        chk("b2b done spacing", t1 - t0, 41);
        tick();
        chk("b2b end ready", ready0, 1'b1);

        // Abort an FF frame in its 17th cycle
        data0 = 8'hFF; valid0 = 1'b1;
        tick();
        valid0 = 1'b0;
        repeat (16) tick();
        chk("pre-abort busy", busy0, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("abort tx", tx0, 1'b1);
        chk("abort busy", busy0, 1'b0);
        chk("abort ready", ready0, 1'b0);
        chk("abort done", done0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort hold done", done0, 1'b0);
            chk("abort hold tx", tx0, 1'b1);
        end
        rst = 1'b0;
        tick();
        chk("abort rel ready", ready0, 1'b1);
        chk("abort rel busy", busy0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no resume tx", tx0, 1'b1);
            chk("no resume done", done0, 1'b0);
        end
        data0 = 8'h81; valid0 = 1'b1;
        frame(1'b0, 4, 10'h302, 1'b0, 8'h00, 1'b0, tdummy);
        tick();
        chk("81 end ready", ready0, 1'b1);

        // One clock per bit
        data1 = 8'h96; valid1 = 1'b1;
        frame(1'b1, 1, 10'h32C, 1'b0, 8'h00, 1'b0, tdummy);
        tick();
        chk("96 end ready", ready1, 1'b1);
        chk("96 end done", done1, 1'b0);
        chk("96 end tx", tx1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial frame transmitter. It drives the single-bit serial line that the team's flop-based sampling and receive logic captures.
- Accepts one DATA_W-bit word through a valid/ready handshake.
- Shifts the word out LSB first, framed by one start bit (0) and one stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a producer block and the serial link; the line idles high.

Parameters:
DATA_W, 8, payload bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1)

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
data  input  DATA_W  word to transmit; sampled only on acceptance
valid  input  1  producer has a word on data
ready  output  1  transmitter can accept a word (IDLE state only)
tx  output  1  serial line; idle/stop = 1, start = 0
busy  output  1  a frame is in progress
done  output  1  one-cycle pulse in the final cycle of the stop bit

Behaviour:
- Clocking and reset: one clock domain (clk). Reset is asynchronous and active-high (rst).
- While rst=1, all outputs are forced immediately, with no clock edge needed: tx=1, ready=0, busy=0, done=0; FSM=IDLE; counters=0; shift register=0.
- First rising edge after rst deasserts: ready=1.
- All outputs are registered. No combinational path from valid or data to any output.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: ready=1, busy=0, tx=1.
  - Acceptance at edge k occurs when valid=1 and ready=1.
  - On acceptance: data is latched into the shift register; bit counter=0; baud counter=0; FSM->START.
  - After edge k: ready=0, busy=1, tx=0.
- START: tx=0 for CLKS_PER_BIT cycles. Then FSM->DATA and tx=shift[0].
- DATA: each bit is held for CLKS_PER_BIT cycles, then the register shifts right.
  - After DATA_W bits, FSM->STOP and tx=1.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - done=1 during the final cycle of STOP only.
  - At the end of STOP, FSM->IDLE.
- Frame timing from acceptance edge k:
  - First frame cycle = cycle after edge k.
  - done is high in the cycle after edge k+(DATA_W+2)*CLKS_PER_BIT-1.
  - ready=1 and busy=0 after edge k+(DATA_W+2)*CLKS_PER_BIT.
- Baud counter: width $clog2(CLKS_PER_BIT)+1. It counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - CLKS_PER_BIT=1 is legal: one cycle per bit, no counter stall.
- Data stability: data and valid are ignored while busy=1. The latched word is unaffected by later changes to data.
- Back-to-back frames: a producer holding valid=1 gets the next acceptance on the first IDLE cycle.
  - Result: the line stays high for exactly CLKS_PER_BIT+1 cycles between frames (stop bit plus one IDLE cycle).
- valid dropped before acceptance: no frame starts, tx stays 1.
- Reset mid-frame: the frame is aborted and tx returns to 1 asynchronously.
  - No done pulse for the aborted frame.
  - After reset release: ready=1 on the first clock edge; no frame resumes.
- done and ready are never high in the same cycle.
- busy equals the complement of ready outside reset.

Test Plan:
1. Reset: assert rst mid-cycle with the clock running -> tx=1, ready=0, busy=0, done=0 immediately; release -> ready=1 after the next edge.
2. Single frame: DATA_W=8, CLKS_PER_BIT=4, data=8'hA5 accepted at edge k -> tx holds each of the following for 4 cycles: 0 | 1,0,1,0,0,1,0,1 | 1. done is high only in cycle 40 after acceptance; ready=1 after edge k+40.
3. Back-to-back: valid held high with 8'h00 then 8'hFF -> each frame is 40 cycles; the line is high for exactly 5 cycles between the two frames' start bits; two done pulses 41 cycles apart.
4. Ignore while busy: change data to 8'h3C and toggle valid during the 8'hA5 frame -> serial pattern unchanged from scenario 2; no extra frame.
5. Abort: assert rst at cycle 17 of an 8'hFF frame -> tx=1 immediately; no done pulse; after release, a frame of 8'h81 transmits correctly (0 | 1,0,0,0,0,0,0,1 | 1).
6. CLKS_PER_BIT=1, data=8'h96 -> 10-cycle frame 0,0,1,1,0,1,0,0,1,1; done in cycle 10.
